sd_host_regfile: RTL and testbench



---
 rtl/sd_host_regfile_pkg.sv | 50 +++++
 rtl/sd_host_regfile_if.sv | 13 +
 rtl/sd_int_status_reg.sv | 31 +++
 rtl/sd_host_regfile.sv | 147 ++++++++++++++
 tb/tb_sd_host_regfile.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/sd_host_regfile_pkg.sv
// Shared constants for the SD host register file: register map, field widths
// and bit positions inside present_state and software_reset.
package sd_host_regfile_pkg;

  localparam int ADR_W = 5;

  localparam logic [ADR_W-1:0] ADR_BLOCK_SIZE    = 5'd0;
  localparam logic [ADR_W-1:0] ADR_BLOCK_COUNT   = 5'd1;
  localparam logic [ADR_W-1:0] ADR_ARGUMENT      = 5'd2;
  localparam logic [ADR_W-1:0] ADR_TRANSFER_MODE = 5'd3;
  localparam logic [ADR_W-1:0] ADR_COMMAND       = 5'd4;
  localparam logic [ADR_W-1:0] ADR_RESPONSE      = 5'd5;
  localparam logic [ADR_W-1:0] ADR_PRESENT_STATE = 5'd6;
  localparam logic [ADR_W-1:0] ADR_TIMEOUT_CTRL  = 5'd7;
  localparam logic [ADR_W-1:0] ADR_SW_RESET      = 5'd8;
  localparam logic [ADR_W-1:0] ADR_NORMAL_INT    = 5'd9;
  localparam logic [ADR_W-1:0] ADR_ERR_INT       = 5'd10;

  localparam int DATA_W          = 128;
  localparam int BLOCK_SIZE_W    = 12;
  localparam int BLOCK_COUNT_W   = 16;
  localparam int ARGUMENT_W      = 32;
  localparam int TRANSFER_MODE_W = 16;
  localparam int COMMAND_W       = 16;
  localparam int RESPONSE_W      = 128;
  localparam int PRESENT_STATE_W = 16;
  localparam int TIMEOUT_CTRL_W  = 16;
  localparam int SW_RESET_W      = 3;
  localparam int INT_STATUS_W    = 16;

  localparam int PS_CMD_INHIBIT = 0;
  localparam int PS_DAT_INHIBIT = 1;

  localparam int SRST_ALL = 0;
  localparam int SRST_CMD = 1;
  localparam int SRST_DAT = 2;

  // Command register bit that announces a data phase.
  localparam int CMD_DATA_PRESENT = 5;

  function automatic logic is_writable(input logic [ADR_W-1:0] adr);
    case (adr)
      ADR_BLOCK_SIZE, ADR_BLOCK_COUNT, ADR_ARGUMENT, ADR_TRANSFER_MODE,
      ADR_COMMAND, ADR_TIMEOUT_CTRL, ADR_SW_RESET, ADR_NORMAL_INT,
      ADR_ERR_INT: is_writable = 1'b1;
      default:     is_writable = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sd_host_regfile_if.sv
// Register bus between the Wishbone slave (master side) and the register file.
interface sd_host_regfile_if;
  import sd_host_regfile_pkg::*;

  logic [ADR_W-1:0]  adr_i;
  logic              reg_write_en;
  logic              reg_read_en;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;

  modport master (output adr_i, reg_write_en, reg_read_en, data_i, input data_o);
  modport slave  (input adr_i, reg_write_en, reg_read_en, data_i, output data_o);
endinterface

// File: rtl/sd_int_status_reg.sv
// 16-bit sticky interrupt status register: write-one-to-clear, a set event in
// the same cycle as a clear wins, synchronous clear for software reset.
module sd_int_status_reg
  import sd_host_regfile_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    write_en,
  input  logic [INT_STATUS_W-1:0] write_data,
  input  logic [INT_STATUS_W-1:0] event_in,
  output logic [INT_STATUS_W-1:0] status
);

  logic [INT_STATUS_W-1:0] clr_mask;

  assign clr_mask = write_en ? write_data : '0;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of process order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status <= '0;
    end else if (clear) begin
      status <= '0;
    end else begin
      status <= (status & ~clr_mask) | event_in;
    end
  end

endmodule

// File: rtl/sd_host_regfile.sv
// SD host controller register file behind the Wishbone slave.
// Optional: define SDREG_ILLEGAL_ACCESS_EN to flag writes to RO/reserved
// addresses in error_int_status[15].
module sd_host_regfile
  import sd_host_regfile_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  sd_host_regfile_if.slave           bus,
  input  logic                       command_complete,
  input  logic [RESPONSE_W-1:0]      response_i,
  input  logic [INT_STATUS_W-1:0]    error_interrupt_status_i,
  input  logic [INT_STATUS_W-1:0]    normal_interrupt_status_i,
  output logic [BLOCK_SIZE_W-1:0]    block_size,
  output logic [BLOCK_COUNT_W-1:0]   block_count,
  output logic [ARGUMENT_W-1:0]      argument,
  output logic [TRANSFER_MODE_W-1:0] transfer_mode,
  output logic [COMMAND_W-1:0]       command,
  output logic [PRESENT_STATE_W-1:0] present_state,
  output logic [TIMEOUT_CTRL_W-1:0]  timeout_control,
  output logic [SW_RESET_W-1:0]      software_reset,
  output logic [INT_STATUS_W-1:0]    error_interrupt_status_o
);

  logic                    wr;
  logic                    cmd_wr;
  logic                    cmd_inhibit;
  logic                    dat_inhibit;
  logic [RESPONSE_W-1:0]   response;
  logic [INT_STATUS_W-1:0] normal_status;
  logic [INT_STATUS_W-1:0] error_status;
  logic [INT_STATUS_W-1:0] normal_event;
  logic [INT_STATUS_W-1:0] error_event;

  // A pending software reset swallows any bus write in the cycle it acts.
  assign wr     = bus.reg_write_en && (software_reset == '0);
  assign cmd_wr = wr && (bus.adr_i == ADR_COMMAND);

  assign present_state = {{(PRESENT_STATE_W-2){1'b0}}, dat_inhibit, cmd_inhibit};
  assign normal_event  = normal_interrupt_status_i | {{(INT_STATUS_W-1){1'b0}}, command_complete};

`ifdef SDREG_ILLEGAL_ACCESS_EN
  assign error_event = error_interrupt_status_i |
                       {(wr && !is_writable(bus.adr_i)), {(INT_STATUS_W-1){1'b0}}};
`else
  assign error_event = error_interrupt_status_i;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      block_size      <= '0;
      block_count     <= '0;
      argument        <= '0;
      transfer_mode   <= '0;
      command         <= '0;
      timeout_control <= '0;
      software_reset  <= '0;
      response        <= '0;
      cmd_inhibit     <= 1'b0;
      dat_inhibit     <= 1'b0;
    end else begin
      software_reset <= '0;
      if (software_reset[SRST_ALL]) begin
        block_size      <= '0;
        block_count     <= '0;
        argument        <= '0;
        transfer_mode   <= '0;
        command         <= '0;
        timeout_control <= '0;
        response        <= '0;
        cmd_inhibit     <= 1'b0;
        dat_inhibit     <= 1'b0;
      end else begin
        if (software_reset[SRST_CMD]) begin
          cmd_inhibit <= 1'b0;
          response    <= '0;
        end else begin
          if (command_complete) response <= response_i;
          // A new command in the completing cycle keeps the inhibit set.
          if (cmd_wr)                cmd_inhibit <= 1'b1;
          else if (command_complete) cmd_inhibit <= 1'b0;
        end

        if (software_reset[SRST_DAT])                   dat_inhibit <= 1'b0;
        else if (cmd_wr && bus.data_i[CMD_DATA_PRESENT]) dat_inhibit <= 1'b1;

        if (wr) begin
          case (bus.adr_i)
            ADR_BLOCK_SIZE:    block_size      <= bus.data_i[BLOCK_SIZE_W-1:0];
            ADR_BLOCK_COUNT:   block_count     <= bus.data_i[BLOCK_COUNT_W-1:0];
            ADR_ARGUMENT:      argument        <= bus.data_i[ARGUMENT_W-1:0];
            ADR_TRANSFER_MODE: transfer_mode   <= bus.data_i[TRANSFER_MODE_W-1:0];
            ADR_COMMAND:       command         <= bus.data_i[COMMAND_W-1:0];
            ADR_TIMEOUT_CTRL:  timeout_control <= bus.data_i[TIMEOUT_CTRL_W-1:0];
            ADR_SW_RESET:      software_reset  <= bus.data_i[SW_RESET_W-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  sd_int_status_reg u_normal_int (
    .clock      (clock),
    .reset      (reset),
    .clear      (software_reset[SRST_ALL]),
    .write_en   (wr && (bus.adr_i == ADR_NORMAL_INT)),
    .write_data (bus.data_i[INT_STATUS_W-1:0]),
    .event_in   (normal_event),
    .status     (normal_status)
  );

  sd_int_status_reg u_error_int (
    .clock      (clock),
    .reset      (reset),
    .clear      (software_reset[SRST_ALL]),
    .write_en   (wr && (bus.adr_i == ADR_ERR_INT)),
    .write_data (bus.data_i[INT_STATUS_W-1:0]),
    .event_in   (error_event),
    .status     (error_status)
  );

  assign error_interrupt_status_o = error_status;

  // NOTE: data_o gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.data_o = '0;
    if (bus.reg_read_en) begin
      case (bus.adr_i)
        ADR_BLOCK_SIZE:    bus.data_o = DATA_W'(block_size);
        ADR_BLOCK_COUNT:   bus.data_o = DATA_W'(block_count);
        ADR_ARGUMENT:      bus.data_o = DATA_W'(argument);
        ADR_TRANSFER_MODE: bus.data_o = DATA_W'(transfer_mode);
        ADR_COMMAND:       bus.data_o = DATA_W'(command);
        ADR_RESPONSE:      bus.data_o = response;
        ADR_PRESENT_STATE: bus.data_o = DATA_W'(present_state);
        ADR_TIMEOUT_CTRL:  bus.data_o = DATA_W'(timeout_control);
        ADR_SW_RESET:      bus.data_o = DATA_W'(software_reset);
        ADR_NORMAL_INT:    bus.data_o = DATA_W'(normal_status);
        ADR_ERR_INT:       bus.data_o = DATA_W'(error_status);
        default:           bus.data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_host_regfile.sv
// Directed self-checking bench for sd_host_regfile; honours
// SDREG_ILLEGAL_ACCESS_EN when it is defined for the build.
module tb_sd_host_regfile;
  import sd_host_regfile_pkg::*;

  logic         clock;
  logic         reset;
  logic         command_complete;
  logic [127:0] response_i;
  logic [15:0]  error_interrupt_status_i;
  logic [15:0]  normal_interrupt_status_i;
  logic [11:0]  block_size;
  logic [15:0]  block_count;
  logic [31:0]  argument;
  logic [15:0]  transfer_mode;
  logic [15:0]  command;
  logic [15:0]  present_state;
  logic [15:0]  timeout_control;
  logic [2:0]   software_reset;
  logic [15:0]  error_interrupt_status_o;

  int checks = 0;
  int errors = 0;

  sd_host_regfile_if bus ();

  sd_host_regfile dut (
    .clock                     (clock),
    .reset                     (reset),
    .bus                       (bus),
    .command_complete          (command_complete),
    .response_i                (response_i),
    .error_interrupt_status_i  (error_interrupt_status_i),
    .normal_interrupt_status_i (normal_interrupt_status_i),
    .block_size                (block_size),
    .block_count               (block_count),
    .argument                  (argument),
    .transfer_mode             (transfer_mode),
    .command                   (command),
    .present_state             (present_state),
    .timeout_control           (timeout_control),
    .software_reset            (software_reset),
    .error_interrupt_status_o  (error_interrupt_status_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic read(input logic [4:0] adr, output logic [127:0] value);
    bus.adr_i       = adr;
    bus.reg_read_en = 1'b1;
    #1;
    value = bus.data_o;
    bus.reg_read_en = 1'b0;
  endtask

  task automatic write(input logic [4:0] adr, input logic [127:0] data);
    bus.adr_i        = adr;
    bus.data_i       = data;
    bus.reg_write_en = 1'b1;
    tick();
    bus.reg_write_en = 1'b0;
  endtask

  logic [127:0] rd;
  logic [15:0]  exp_err;

  initial begin
    reset                     = 1'b1;
    command_complete          = 1'b0;
    response_i                = '0;
    error_interrupt_status_i  = '0;
    normal_interrupt_status_i = '0;
    bus.adr_i                 = '0;
    bus.reg_write_en          = 1'b0;
    bus.reg_read_en           = 1'b0;
    bus.data_i                = '0;
    #2;
    check("rst_argument", argument, 0);
    check("rst_present_state", present_state, 0);
    check("rst_err_o", error_interrupt_status_o, 0);
    @(negedge clock);
    reset = 1'b0;

    // Mid-run asynchronous reset
    write(ADR_ARGUMENT, 128'hDEADBEEF);
    check("argument_written", argument, 32'hDEADBEEF);
    #2 reset = 1'b1;
    #1;
    check("async_rst_argument", argument, 0);
    check("async_rst_block_size", block_size, 0);
    read(ADR_ARGUMENT, rd);
    check("async_rst_read_adr2", rd, 0);
    reset = 1'b0;
    tick();

    // Width truncation and read gating
    write(ADR_BLOCK_SIZE, 128'hFFFF);
    check("block_size_trunc", block_size, 12'hFFF);
    read(ADR_BLOCK_SIZE, rd);
    check("read_block_size", rd, 128'h0FFF);
    bus.reg_read_en = 1'b0;
    #1;
    check("read_disabled", bus.data_o, 0);

    // Command write sets both inhibits; same-cycle read shows the old value
    bus.adr_i        = ADR_COMMAND;
    bus.data_i       = 128'h0020;
    bus.reg_write_en = 1'b1;
    bus.reg_read_en  = 1'b1;
    #1;
    check("read_during_write_old", bus.data_o, 0);
    tick();
    bus.reg_write_en = 1'b0;
    check("read_after_write_new", bus.data_o, 128'h0020);
    bus.reg_read_en = 1'b0;
    check("ps_after_cmd", present_state, 16'h0003);

    command_complete = 1'b1;
    response_i       = 128'h1234;
    tick();
    command_complete = 1'b0;
    response_i       = '0;
    check("ps_after_complete", present_state, 16'h0002);
    read(ADR_RESPONSE, rd);
    check("response_captured", rd, 128'h1234);
    read(ADR_NORMAL_INT, rd);
    check("normal_int_cc_bit0", rd, 128'h0001);

    // Command write and completion in one cycle: set wins
    command_complete = 1'b1;
    response_i       = 128'h5678;
    write(ADR_COMMAND, 128'h0001);
    command_complete = 1'b0;
    check("ps_set_wins", present_state, 16'h0003);
    command_complete = 1'b1;
    tick();
    command_complete = 1'b0;
    check("ps_cleared", present_state, 16'h0002);

    // Sticky RW1C error status with set-wins
    error_interrupt_status_i = 16'h0004;
    tick();
    error_interrupt_status_i = '0;
    check("err_sticky_set", error_interrupt_status_o, 16'h0004);
    error_interrupt_status_i = 16'h0004;
    write(ADR_ERR_INT, 128'h0004);
    error_interrupt_status_i = '0;
    check("err_set_wins", error_interrupt_status_o, 16'h0004);
    write(ADR_ERR_INT, 128'h0004);
    check("err_w1c", error_interrupt_status_o, 16'h0000);

    // Software reset all; a write during the active reset cycle is lost
    write(ADR_TIMEOUT_CTRL, 128'h000E);
    check("timeout_written", timeout_control, 16'h000E);
    write(ADR_SW_RESET, 128'h1);
    check("srst_pulse", software_reset, 3'b001);
    check("timeout_held", timeout_control, 16'h000E);
    write(ADR_BLOCK_COUNT, 128'h0005);
    check("srst_selfclear", software_reset, 3'b000);
    check("srst_timeout_cleared", timeout_control, 16'h0000);
    check("srst_ps_cleared", present_state, 16'h0000);
    check("srst_block_size_cleared", block_size, 12'h000);
    check("srst_write_lost", block_count, 16'h0000);
    read(ADR_NORMAL_INT, rd);
    check("srst_normal_int_cleared", rd, 0);

    // Command reset clears command inhibit and response only
    command_complete = 1'b1;
    response_i       = 128'hABCD;
    write(ADR_COMMAND, 128'h0020);
    command_complete = 1'b0;
    check("ps_before_cmd_reset", present_state, 16'h0003);
    write(ADR_SW_RESET, 128'h2);
    tick();
    check("cmd_reset_ps", present_state, 16'h0002);
    read(ADR_RESPONSE, rd);
    check("cmd_reset_response", rd, 0);
    write(ADR_SW_RESET, 128'h4);
    tick();
    check("dat_reset_ps", present_state, 16'h0000);

    // Writes to reserved and read-only addresses
    write(5'd20, 128'hFFFF);
    write(ADR_PRESENT_STATE, 128'hFFFF);
`ifdef SDREG_ILLEGAL_ACCESS_EN
    exp_err = 16'h8000;
`else
    exp_err = 16'h0000;
`endif
    check("illegal_err_status", error_interrupt_status_o, exp_err);
    check("illegal_ps_unchanged", present_state, 16'h0000);
    check("illegal_command_unchanged", command, 16'h0020);
    read(5'd20, rd);
    check("reserved_reads_zero", rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
